// File: rtl/ser8_pkg.sv
// ---------------------------------------------------------------------------
// ser8_pkg -- shared constants and state encoding for the ser8_tx serializer.
//
// Contents:
//   DATA_W      width of the parallel byte (8)
//   IDX_W       width of the bit index (3)
//   state_t     serializer states; PAR exists only with SER8_TX_PARITY_EN
//   even_parity XOR of the held byte (only with SER8_TX_PARITY_EN)
//
// Build option: define SER8_TX_PARITY_EN to add the trailing parity bit.
// ---------------------------------------------------------------------------
package ser8_pkg;

   localparam int DATA_W = 8;
   localparam int IDX_W  = 3;

`ifdef SER8_TX_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`else
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

endpackage

// File: rtl/ser8_tx_if.sv
// ---------------------------------------------------------------------------
// ser8_tx_if -- load handshake and serial output bundle of ser8_tx.
//
// Signals:
//   data        parallel byte offered by the producer
//   load_valid  producer offers data this cycle
//   load_ready  serializer accepts data this cycle
//   sout        serial bit stream
//   sout_valid  sout carries a frame bit this cycle
//   sout_last   current sout bit is the final bit of the frame
//
// Modports: master = producer/consumer side, slave = the serializer.
// ---------------------------------------------------------------------------
interface ser8_tx_if;
   import ser8_pkg::*;

   logic [DATA_W-1:0] data;
   logic              load_valid;
   logic              load_ready;
   logic              sout;
   logic              sout_valid;
   logic              sout_last;

   modport master (
      output data,
      output load_valid,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  sout_last
   );

   modport slave (
      input  data,
      input  load_valid,
      output load_ready,
      output sout,
      output sout_valid,
      output sout_last
   );

endinterface

// File: rtl/mux8.sv
// ---------------------------------------------------------------------------
// mux8 -- 8:1 single-bit multiplexer cell.
//
// Ports:
//   d    8 data inputs
//   sel  3-bit select
//   y    selected bit d[sel]
// ---------------------------------------------------------------------------
module mux8 (
   input  logic [7:0] d,
   input  logic [2:0] sel,
   output logic       y
);

   assign y = d[sel];

endmodule

// File: rtl/ser8_cnt.sv
// ---------------------------------------------------------------------------
// ser8_cnt -- 3-bit bit-index counter for ser8_tx.
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-high reset (index -> 0)
//   clr    synchronous clear (takes priority over en)
//   en     increment by one
//   q      current bit index
// ---------------------------------------------------------------------------
module ser8_cnt
   import ser8_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ser8_tx.sv
// ---------------------------------------------------------------------------
// ser8_tx -- byte-to-serial transmitter, LSB first, with valid/ready load.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous active-high reset; aborts any frame in progress
//   bus    ser8_tx_if.slave: data/load_valid in, load_ready/sout/
//          sout_valid/sout_last out
//
// Parameter:
//   IDLE_LEVEL  level driven on sout while no frame is active
//
// Build option: SER8_TX_PARITY_EN appends an even-parity bit after bit 7
// (9-bit frame, sout_last on the parity bit). Without it the frame is
// 8 bits and the PAR state and parity logic do not exist.
//
// A byte accepted at edge N appears on sout as bit 0 in the cycle after
// edge N. load_ready rises on the final frame bit so a new byte can be
// taken on that same edge, giving back-to-back frames with no gap.
// ---------------------------------------------------------------------------
module ser8_tx
   import ser8_pkg::*;
#(
   parameter logic IDLE_LEVEL = 1'b0
)
(
   input  logic     clk,
   input  logic     reset,
   ser8_tx_if.slave bus
);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] hold;
   logic [IDX_W-1:0]  idx;
   logic              at_last_idx;
   logic              ready;
   logic              accept;
   logic              cnt_clr;
   logic              cnt_en;
   logic              data_bit;
   logic              sout;
   logic              sout_valid;
   logic              sout_last;

   assign at_last_idx = (idx == IDX_W'(DATA_W - 1));

   // Ready depends only on state/index (never on load_valid), so the
   // accept path stays free of combinational loops. Reset forces it low.
   always_comb begin
      ready = 1'b0;
      unique case (state)
         IDLE:  ready = 1'b1;
`ifdef SER8_TX_PARITY_EN
         SHIFT: ready = 1'b0;
         PAR:   ready = 1'b1;
`else
         SHIFT: ready = at_last_idx;
`endif
         default: ready = 1'b0;
      endcase
      if (reset) begin
         ready = 1'b0;
      end
   end

   assign accept = bus.load_valid & ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            hold <= bus.data;
         end
      end
   end

   ser8_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .q     (idx)
   );

   mux8 u_mux (
      .d   (hold),
      .sel (idx),
      .y   (data_bit)
   );

   // Next state, counter control and serial outputs. The index is cleared
   // whenever the data phase ends so every frame starts at bit 0.
   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      sout       = IDLE_LEVEL;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = SHIFT;
               cnt_clr    = 1'b1;
            end
         end
         SHIFT: begin
            sout       = data_bit;
            sout_valid = 1'b1;
            if (!at_last_idx) begin
               cnt_en = 1'b1;
            end else begin
               cnt_clr = 1'b1;
`ifdef SER8_TX_PARITY_EN
               state_next = PAR;
`else
               sout_last = 1'b1;
               if (!accept) begin
                  state_next = IDLE;
               end
`endif
            end
         end
`ifdef SER8_TX_PARITY_EN
         PAR: begin
            sout       = even_parity(hold);
            sout_valid = 1'b1;
            sout_last  = 1'b1;
            cnt_clr    = 1'b1;
            state_next = accept ? SHIFT : IDLE;
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.load_ready = ready;
   assign bus.sout       = sout;
   assign bus.sout_valid = sout_valid;
   assign bus.sout_last  = sout_last;

endmodule

// File: tb/tb_ser8_tx.sv
// ---------------------------------------------------------------------------
// tb_ser8_tx -- self-checking bench for ser8_tx.
// Table of bytes with their expected serial order, hand sequences for
// back-to-back frames, mid-frame reset and idle level, then random traffic
// against a queue-based frame model.
// ---------------------------------------------------------------------------
module tb_ser8_tx;

`ifdef SER8_TX_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic clk = 1'b0;
   logic reset;

   ser8_tx_if bus ();
   ser8_tx_if bus_hi ();

   ser8_tx #(.IDLE_LEVEL(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ser8_tx #(.IDLE_LEVEL(1'b1)) dut_hi (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_hi)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // seq lists the expected serial bits in transmit order (seq[0] first);
   // par is the even-parity bit that follows when parity is built in.
   typedef struct packed {
      logic [7:0] d;
      logic [0:7] seq;
      logic       par;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at a negedge with the DUT ready.
   task automatic wait_ready();
      int budget;
      budget = 0;
      while (bus.load_ready !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("wait_ready", bus.load_ready, 1'b1);
   endtask

   // Single frame from idle; data is changed after acceptance and must not
   // affect the transmitted bits.
   task automatic run_frame(input vec_t v, input logic [7:0] after);
      logic exp_bit;
      wait_ready();
      bus.data       = v.d;
      bus.load_valid = 1'b1;
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.data       = after;
      for (int k = 1; k <= FL; k++) begin
         exp_bit = (k <= 8) ? v.seq[k-1] : v.par;
         check($sformatf("frame_%0h_sout_c%0d", v.d, k), bus.sout, exp_bit);
         check($sformatf("frame_%0h_valid_c%0d", v.d, k), bus.sout_valid, 1'b1);
         check($sformatf("frame_%0h_last_c%0d", v.d, k), bus.sout_last, (k == FL));
         check($sformatf("frame_%0h_ready_c%0d", v.d, k), bus.load_ready, (k == FL));
         @(negedge clk);
      end
      check($sformatf("frame_%0h_idle_valid", v.d), bus.sout_valid, 1'b0);
      check($sformatf("frame_%0h_idle_sout", v.d), bus.sout, 1'b0);
      check($sformatf("frame_%0h_idle_ready", v.d), bus.load_ready, 1'b1);
   endtask

   // load_valid held high: byte a then byte b with no gap.
   task automatic run_b2b(input vec_t a, input vec_t b);
      logic exp_bit;
      int   kk;
      wait_ready();
      bus.data       = a.d;
      bus.load_valid = 1'b1;
      @(negedge clk);
      bus.data = b.d;
      for (int k = 1; k <= 2 * FL; k++) begin
         kk = (k <= FL) ? k : k - FL;
         if (k <= FL) exp_bit = (kk <= 8) ? a.seq[kk-1] : a.par;
         else         exp_bit = (kk <= 8) ? b.seq[kk-1] : b.par;
         check($sformatf("b2b_sout_c%0d", k), bus.sout, exp_bit);
         check($sformatf("b2b_valid_c%0d", k), bus.sout_valid, 1'b1);
         check($sformatf("b2b_last_c%0d", k), bus.sout_last, (k == FL || k == 2 * FL));
         check($sformatf("b2b_ready_c%0d", k), bus.load_ready, (k == FL || k == 2 * FL));
         if (k == FL + 1) bus.load_valid = 1'b0;
         @(negedge clk);
      end
      check("b2b_gap_after", bus.sout_valid, 1'b0);
   endtask

   // Random traffic against a frame-queue model: the queue holds the bits
   // still to be sent; ready means at most the final bit remains.
   task automatic run_random(input int cycles);
      logic       mq[$];
      logic       v;
      logic [7:0] d;
      logic       acc;
      for (int c = 0; c < cycles; c++) begin
         v = ($urandom_range(0, 9) < 7);
         d = 8'($urandom);
         bus.load_valid = v;
         bus.data       = d;
         if (mq.size() > 0) begin
            check("rnd_sout", bus.sout, mq[0]);
            check("rnd_valid", bus.sout_valid, 1'b1);
            check("rnd_last", bus.sout_last, (mq.size() == 1));
         end else begin
            check("rnd_sout_idle", bus.sout, 1'b0);
            check("rnd_valid_idle", bus.sout_valid, 1'b0);
            check("rnd_last_idle", bus.sout_last, 1'b0);
         end
         check("rnd_ready", bus.load_ready, (mq.size() <= 1));
         acc = v && (mq.size() <= 1);
         @(posedge clk);
         if (mq.size() > 0) void'(mq.pop_front());
         if (acc) begin
            for (int i = 0; i < 8; i++) mq.push_back(d[i]);
            if (FL == 9) mq.push_back(^d);
         end
         @(negedge clk);
      end
      bus.load_valid = 1'b0;
      repeat (FL + 1) @(negedge clk);
      check("rnd_drain_idle", bus.sout_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{d: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
      tbl[1] = '{d: 8'h01, seq: 8'b1000_0000, par: 1'b1};
      tbl[2] = '{d: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
      tbl[3] = '{d: 8'h07, seq: 8'b1110_0000, par: 1'b1};
      tbl[4] = '{d: 8'h03, seq: 8'b1100_0000, par: 1'b0};
      tbl[5] = '{d: 8'h55, seq: 8'b1010_1010, par: 1'b0};
      tbl[6] = '{d: 8'h80, seq: 8'b0000_0001, par: 1'b1};
      tbl[7] = '{d: 8'hD2, seq: 8'b0100_1011, par: 1'b0};

      bus.data          = 8'h00;
      bus.load_valid    = 1'b0;
      bus_hi.data       = 8'h00;
      bus_hi.load_valid = 1'b0;
      reset             = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_ready", bus.load_ready, 1'b0);
      check("rst_sout", bus.sout, 1'b0);
      check("rst_valid", bus.sout_valid, 1'b0);
      check("rst_last", bus.sout_last, 1'b0);
      check("rst_hi_sout", bus_hi.sout, 1'b1);
      check("rst_hi_ready", bus_hi.load_ready, 1'b0);
      reset = 1'b0;
      #1;
      check("release_ready", bus.load_ready, 1'b1);

      // Idle level high instance, no load for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_hi_sout", bus_hi.sout, 1'b1);
         check("idle_hi_valid", bus_hi.sout_valid, 1'b0);
         check("idle_hi_ready", bus_hi.load_ready, 1'b1);
         check("idle_lo_sout", bus.sout, 1'b0);
      end

      // Table-driven single frames.
      for (int i = 0; i < 8; i++) begin
         run_frame(tbl[i], ~tbl[i].d);
      end

      // Data toggled 55 -> AA during the frame.
      run_frame(tbl[5], 8'hAA);

      // Back-to-back 01 then FF.
      run_b2b(tbl[1], tbl[2]);

      // Reset pulsed during bit 4 of 3C (bit 4 of 3C is 1).
      wait_ready();
      bus.data       = 8'h3C;
      bus.load_valid = 1'b1;
      @(negedge clk);
      bus.load_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_bit4_sout", bus.sout, 1'b1);
      check("abort_bit4_valid", bus.sout_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("abort_sout", bus.sout, 1'b0);
      check("abort_valid", bus.sout_valid, 1'b0);
      check("abort_last", bus.sout_last, 1'b0);
      check("abort_ready", bus.load_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_release_ready", bus.load_ready, 1'b1);
      @(negedge clk);
      check("abort_no_resume", bus.sout_valid, 1'b0);
      run_frame(tbl[1], 8'h00);

      // Random traffic with the frame model.
      run_random(400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ser8_tx.md
SER8_TX -- requirements
Module: ser8_tx

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0, value driven on sout when no frame is active.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data  input  8  parallel byte to transmit, sampled at load acceptance.
REQ-005 SHALL have port load_valid  input  1  producer offers data this cycle.
REQ-006 SHALL have port load_ready  output  1  block accepts data this cycle.
REQ-007 SHALL have port sout  output  1  serial bit stream.
REQ-008 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 SHALL have port sout_last  output  1  current sout bit is the final bit of the frame.

Function
REQ-010 SHALL implement states IDLE, SHIFT and PAR (PAR only present per REQ-024).
REQ-011 SHALL accept a byte when load_valid and load_ready are both high at a rising clk edge; data is captured into an 8-bit holding register at that edge.
REQ-012 SHALL drive load_ready high in IDLE, and also in SHIFT when bit index is 7 and no parity bit follows; low otherwise.
REQ-013 SHALL enter SHIFT with a 3-bit bit index of 0 on acceptance; sout = held bit 0 in the first cycle after acceptance (latency 1 cycle).
REQ-014 SHALL transmit LSB first: held bit k on sout in cycle k+1 after acceptance, k = 0..7, with sout_valid high for each.
REQ-015 SHALL increment the bit index by 1 per cycle in SHIFT; index 7 ends the data phase (no wrap-around into a new frame without a new acceptance).
REQ-016 SHALL, when bit index is 7 and load is accepted in the same cycle (no parity), reload the holding register, reset index to 0 and remain in SHIFT (back-to-back frames, no idle gap).
REQ-017 SHALL, when bit index is 7 without parity and no acceptance, return to IDLE.
REQ-018 SHALL drive sout = IDLE_LEVEL, sout_valid = 0, sout_last = 0 in IDLE.
REQ-019 SHALL assert sout_last for exactly one cycle per frame, coincident with the final frame bit.
REQ-020 SHALL ignore data and load_valid changes while load_ready is low; held byte is stable for the whole frame.

Reset
REQ-021 SHALL, while reset is high, force state IDLE, bit index 0, holding register 8'h00, load_ready 0, sout IDLE_LEVEL, sout_valid 0, sout_last 0, independent of clk.
REQ-022 SHALL abort any frame in progress on reset assertion; no partial frame resumes after release.
REQ-023 SHALL raise load_ready in the first cycle after reset deasserts (IDLE).

Configuration
REQ-024 SHALL, with macro SER8_TX_PARITY_EN defined, append one even-parity bit (XOR of the 8 held bits) in state PAR after bit 7, making a 9-bit frame; sout_last on the parity bit; load_ready high in PAR (back-to-back from PAR as in REQ-016), low in SHIFT index 7.
REQ-025 SHALL, without SER8_TX_PARITY_EN, omit state PAR and parity logic entirely; frame is 8 bits with sout_last on bit 7.

Structure
REQ-026 SHALL place the state enumeration typedef, DATA_W = 8 and IDX_W = 3 constants in shared package ser8_pkg.
REQ-027 SHALL select the transmitted bit with the existing mux8 cell, index bits on its select inputs.
REQ-028 SHALL implement the bit index as one sub-module ser8_cnt (3-bit counter with async active-high reset, clear and enable inputs).

Verification
REQ-029 SHALL cover: reset release, load data 8'hA5 -> sout 1,0,1,0,0,1,0,1 in cycles 1..8, sout_last in cycle 8, load_ready 0 in cycles 1..7.
REQ-030 SHALL cover: load_valid held high with 8'h01 then 8'hFF -> 16 contiguous sout_valid cycles, no gap, sout_last in cycles 8 and 16.
REQ-031 SHALL cover: reset pulsed during bit 4 of 8'h3C -> sout IDLE_LEVEL and sout_valid 0 immediately, load_ready 1 the cycle after release, next byte starts at bit 0.
REQ-032 SHALL cover: SER8_TX_PARITY_EN defined, data 8'h07 -> parity bit 1 in cycle 9 with sout_last; 8'h03 -> parity bit 0.
REQ-033 SHALL cover: IDLE_LEVEL = 1'b1, no load_valid for 20 cycles -> sout constant 1, sout_valid 0, load_ready 1.
REQ-034 SHALL cover: data toggled from 8'h55 to 8'hAA during frame -> transmitted bits remain those of 8'h55.
